// File: rtl/switch_conditioner_if.sv
// -----------------------------------------------------------------------------
// switch_conditioner_if
//   Bundle for the slide-switch conditioner. It carries the raw pins going in
//   and the clean levels and edge pulses coming out.
//
//   SwRaw   raw asynchronous switch pins        (master -> slave)
//   SW      debounced registered levels         (slave  -> master)
//   SwRise  one-cycle pulse on a 0->1 change    (slave  -> master)
//   SwFall  one-cycle pulse on a 1->0 change    (slave  -> master)
//
//   The slave modport belongs to the conditioner. The master modport belongs
//   to whoever drives the pins and reads the clean switches.
// -----------------------------------------------------------------------------
interface switch_conditioner_if #(
  parameter int N = 10
);
  logic [N-1:0] SwRaw;
  logic [N-1:0] SW;
  logic [N-1:0] SwRise;
  logic [N-1:0] SwFall;

  modport master (
    output SwRaw,
    input  SW,
    input  SwRise,
    input  SwFall
  );

  modport slave (
    input  SwRaw,
    output SW,
    output SwRise,
    output SwFall
  );
endinterface : switch_conditioner_if

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
//   Cleans up the board slide switches before they reach the cpu SW input.
//   Each bit goes through the same independent path:
//     1. A two-flop synchroniser (s1 -> s2) brings the asynchronous pin into
//        the Clock domain.
//     2. A debounce counter counts how many consecutive edges s2 has
//        disagreed with the current output. When DB_CYCLES edges in a row
//        disagree, the output takes the new value.
//     3. In the same edge that the output flips, a rise or fall pulse is
//        registered, so each pulse lines up with the first cycle of the new
//        level.
//
//   Ports
//     Clock  system clock, all state changes on its rising edge
//     Reset  synchronous active-high reset, takes priority over everything
//     bus    switch_conditioner_if.slave (SwRaw in; SW, SwRise, SwFall out)
//
//   Parameters
//     N          number of switch bits
//     DB_CYCLES  consecutive disagreeing edges needed before SW changes,
//                legal range 1 .. 2**CNT_W
//     CNT_W      width of each per-bit debounce counter
//
//   From the edge that first captures a raw change to the edge that updates
//   SW is DB_CYCLES+2 edges. Every output is a register, so no path exists
//   from SwRaw to an output through logic alone.
// -----------------------------------------------------------------------------
module switch_conditioner #(
  parameter int N         = 10,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20
) (
  input  logic                  Clock,
  input  logic                  Reset,
  switch_conditioner_if.slave   bus
);

  // Terminal count. When the counter holds this value and s2 still disagrees,
  // the count is complete. The counter never goes above this value, so it
  // cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0]     s1_q;
  logic [N-1:0]     s2_q;
  logic [N-1:0]     sw_q;
  logic [N-1:0]     rise_q;
  logic [N-1:0]     fall_q;
  logic [CNT_W-1:0] cnt_q [N];

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  logic [N-1:0]     sw_d;
  logic [N-1:0]     rise_d;
  logic [N-1:0]     fall_d;
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     mismatch;
  logic [N-1:0]     done;

  // Debounce decision for each bit. Only s2 is read here, and s1 is never
  // read, so the first synchroniser flop can settle from metastability.
  always_comb begin
    // NOTE: every signal gets a default before any branch. Without the
    // defaults, a path that skips an assignment would infer a latch.
    sw_d     = sw_q;
    rise_d   = '0;
    fall_d   = '0;
    mismatch = s2_q ^ sw_q;
    done     = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (mismatch[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // The count is complete. Take the new level, raise the matching
          // pulse, and start the next count from zero.
          done[i]   = 1'b1;
          sw_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      // When s2 agrees with SW again, cnt_d stays at its default of zero.
      // This drops any partial count, so glitches never build up over time.
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. The synchroniser
  // chain only works because s2 picks up the value s1 held before this edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      sw_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      // NOTE: the counter array is cleared on reset on purpose. A partial
      // count left over from before reset must not shorten the first
      // debounce after reset.
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= bus.SwRaw;
      s2_q   <= s1_q;
      sw_q   <= sw_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.SW     = sw_q;
  assign bus.SwRise = rise_q;
  assign bus.SwFall = fall_q;

endmodule : switch_conditioner

// File: tb/tb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// tb_switch_conditioner
//   Self-checking bench for switch_conditioner with N=10 and DB_CYCLES=4.
//
//   The reference model treats each bit as a pin delayed by two edges. It
//   counts how many edges in a row that delayed value has disagreed with the
//   model output. After DB_CYCLES disagreeing edges in a row, the output takes
//   the new value and a pulse is emitted.
//
//   The directed scenarios also check the absolute latencies with plain
//   constants.
// -----------------------------------------------------------------------------
module tb_switch_conditioner;

  localparam int N  = 10;
  localparam int DB = 4;

  logic Clock;
  logic Reset;

  switch_conditioner_if #(.N(N)) bus ();

  switch_conditioner #(
    .N         (N),
    .DB_CYCLES (DB),
    .CNT_W     (20)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0] hist [2];       // pin values seen at the last two edges
  logic [N-1:0] m_sw, m_rise, m_fall;
  int           m_run [N];      // consecutive edges the delayed pin disagreed

  task automatic model_step(input logic [N-1:0] raw, input logic rst);
    logic [N-1:0] seen;
    if (rst) begin
      hist[0] = '0; hist[1] = '0;
      m_sw = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      seen   = hist[1];          // pin value from two edges ago
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        if (seen[i] != m_sw[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_sw[i]   = seen[i];
            m_rise[i] = seen[i];
            m_fall[i] = ~seen[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      hist[1] = hist[0];
      hist[0] = raw;
    end
  endtask

  // Apply one cycle of stimulus, step the model on the edge, and compare the
  // outputs 1 time unit later.
  task automatic tick(input logic [N-1:0] raw, input logic rst);
    bus.SwRaw = raw;
    Reset     = rst;
    @(posedge Clock);
    model_step(raw, rst);
    #1;
    check("sw",   32'(bus.SW),     32'(m_sw));
    check("rise", 32'(bus.SwRise), 32'(m_rise));
    check("fall", 32'(bus.SwFall), 32'(m_fall));
    check("rise_fall_excl", 32'(bus.SwRise & bus.SwFall), 32'd0);
  endtask

  initial begin
    int lat, rise_at, fall_at, pulses, rise_cnt;
    logic [N-1:0] rise_val, raw;

    bus.SwRaw = '0;
    Reset     = 1'b1;

    // Reset, then 20 quiet cycles.
    tick('0, 1'b1);
    tick('0, 1'b1);
    check("reset_sw", 32'(bus.SW), 32'd0);
    for (int k = 0; k < 20; k++) tick('0, 1'b0);

    // 0 -> 0A5: expect SW to change at the 6th edge, with a single rise pulse.
    lat = 0; rise_at = 0; pulses = 0; rise_val = '0;
    for (int k = 1; k <= 12; k++) begin
      tick(10'h0A5, 1'b0);
      if (lat == 0 && bus.SW == 10'h0A5) lat = k;
      if (bus.SwRise != '0) begin
        pulses++;
        rise_at  = k;
        rise_val = bus.SwRise;
      end
    end
    check("lat_0a5",     32'(lat),      32'd6);
    check("rise_0a5_at", 32'(rise_at),  32'd6);
    check("rise_0a5_n",  32'(pulses),   32'd1);
    check("rise_0a5_v",  32'(rise_val), 32'h0A5);

    // Bit 8 bounces 1,0,1,0 every 2 cycles, then rests at 0: no change.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(((k / 2) % 2 == 0) ? 10'h1A5 : 10'h0A5, 1'b0);
      if (bus.SwRise[8] || bus.SwFall[8]) pulses++;
    end
    for (int k = 0; k < 10; k++) begin
      tick(10'h0A5, 1'b0);
      if (bus.SwRise[8] || bus.SwFall[8]) pulses++;
    end
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_sw8",    32'(bus.SW[8]), 32'd0);

    // Bit 8 held at 1 long enough to settle, then released to 0.
    for (int k = 0; k < 10; k++) tick(10'h1A5, 1'b0);
    check("b8_high", 32'(bus.SW), 32'h1A5);
    fall_at = 0; rise_cnt = 0; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(10'h0A5, 1'b0);
      if (bus.SwFall[8]) begin pulses++; fall_at = k; end
      if (bus.SwRise != '0) rise_cnt++;
    end
    check("b8_fall_at", 32'(fall_at),  32'd6);
    check("b8_fall_n",  32'(pulses),   32'd1);
    check("b8_no_rise", 32'(rise_cnt), 32'd0);
    check("b8_others",  32'(bus.SW),   32'h0A5);

    // 3FF held, reset on the 3rd edge of the count, then still held.
    tick('0, 1'b1);
    for (int k = 0; k < 3; k++) tick('0, 1'b0);
    tick(10'h3FF, 1'b0);
    tick(10'h3FF, 1'b0);
    tick(10'h3FF, 1'b1);
    check("rst_mid_sw", 32'(bus.SW), 32'd0);
    lat = 0; rise_val = '0;
    for (int k = 1; k <= 12; k++) begin
      tick(10'h3FF, 1'b0);
      if (lat == 0 && bus.SW == 10'h3FF) begin
        lat      = k;
        rise_val = bus.SwRise;
      end
    end
    check("lat_3ff",  32'(lat),      32'd6);
    check("rise_3ff", 32'(rise_val), 32'h3FF);

    // Bit 0 rises in the same cycle that bit 9 falls.
    for (int k = 0; k < 10; k++) tick(10'h200, 1'b0);
    check("pre_sim_sw", 32'(bus.SW), 32'h200);
    rise_at = 0; fall_at = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(10'h001, 1'b0);
      if (bus.SwRise[0]) rise_at = k;
      if (bus.SwFall[9]) fall_at = k;
    end
    check("sim_rise0_at", 32'(rise_at), 32'd6);
    check("sim_fall9_at", 32'(fall_at), 32'd6);

    // Random stimulus: bits flip on their own with varying probability,
    // which mixes short glitches with long holds, plus an occasional reset.
    raw = 10'h001;
    for (int k = 0; k < 800; k++) begin
      logic [N-1:0] flip;
      int           p;
      p = (k < 400) ? 2 : 8;
      flip = '0;
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, p) == 0);
      raw = raw ^ flip;
      tick(raw, ($urandom_range(0, 149) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_switch_conditioner
